// File: rtl/pdm_out.sv
// Multi-channel first-order PDM modulator fed by a double-buffered frame input.
// Build macro PDM_DITHER_EN adds a shared 16-bit LFSR carry-in dither.

module pdm_out_checker #(
    parameter int CHANNELS = 4
) (
    input logic                clk48m,
    input logic                rst_n,
    input logic                mute,
    input logic [CHANNELS-1:0] pdm,
    input logic                underrun
);
    a_underrun_pulse: assert property (@(posedge clk48m) disable iff (!rst_n)
        underrun |=> !underrun);

    a_mute_quiet: assert property (@(posedge clk48m) disable iff (!rst_n)
        mute |=> (pdm == {CHANNELS{1'b0}}));
endmodule

module pdm_out #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 16,
    parameter int DIV      = 24,
    parameter int OSR      = 64
) (
    input  logic                      clk48m,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic                      mute,
    output logic [CHANNELS-1:0]       pdm,
    output logic                      underrun
);
    localparam int PW = $clog2(DIV);
    localparam int SW = $clog2(OSR);
    localparam int DW = CHANNELS * WIDTH;
    localparam logic [PW-1:0]    PCNT_LAST = PW'(DIV - 1);
    localparam logic [SW-1:0]    SCNT_LAST = SW'(OSR - 1);
    localparam logic [DW-1:0]    DATA_ZERO = {DW{1'b0}};
    localparam logic [WIDTH-1:0] ACC_ZERO  = {WIDTH{1'b0}};

    function automatic logic [WIDTH-1:0] to_offset_bin(input logic [WIDTH-1:0] x);
        return {~x[WIDTH-1], x[WIDTH-2:0]};
    endfunction

    logic [PW-1:0]       pcnt_r;
    logic [SW-1:0]       scnt_r;
    logic                tick_s;
    logic                boundary_s;
    logic                accept_s;
    logic [DW-1:0]       staging_r;
    logic                staging_full_r;
    logic [DW-1:0]       active_r;
    logic                underrun_r;
    logic [WIDTH-1:0]    acc_r [CHANNELS];
    logic [WIDTH:0]      sum_s [CHANNELS];
    logic [CHANNELS-1:0] pdm_r;
    logic                cin_s;

    assign tick_s     = (pcnt_r == PCNT_LAST);
    assign boundary_s = tick_s && (scnt_r == SCNT_LAST);
    assign accept_s   = s_valid && !staging_full_r;

    // Prescaler and tick counter within the sample frame.
    always_ff @(posedge clk48m or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_r <= PW'(0);
            scnt_r <= SW'(0);
        end else begin
            if (tick_s) begin
                pcnt_r <= PW'(0);
                if (scnt_r == SCNT_LAST) begin
                    scnt_r <= SW'(0);
                end else begin
                    scnt_r <= scnt_r + SW'(1);
                end
            end else begin
                pcnt_r <= pcnt_r + PW'(1);
            end
        end
    end

    // Staging/active frame buffers; an empty staging slot at a boundary plays midscale.
    always_ff @(posedge clk48m or negedge rst_n) begin
        if (!rst_n) begin
            staging_r      <= DATA_ZERO;
            staging_full_r <= 1'b0;
            active_r       <= DATA_ZERO;
            underrun_r     <= 1'b0;
        end else begin
            underrun_r <= boundary_s && !staging_full_r;
            if (boundary_s) begin
                if (staging_full_r) begin
                    active_r <= staging_r;
                end else begin
                    active_r <= DATA_ZERO;
                end
            end
            // Accept can only happen while staging is empty, so it never races the transfer.
            if (accept_s) begin
                staging_r      <= s_data;
                staging_full_r <= 1'b1;
            end else if (boundary_s) begin
                staging_full_r <= 1'b0;
            end
        end
    end

`ifdef PDM_DITHER_EN
    logic [15:0] lfsr_r;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, free-running on ticks even while muted.
    always_ff @(posedge clk48m or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_r <= 16'hACE1;
        end else if (tick_s) begin
            lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
        end
    end

    assign cin_s = lfsr_r[0];
`else
    assign cin_s = 1'b0;
`endif

    // Per-channel accumulator sum; the carry out is the next PDM bit.
    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            sum_s[k] = {1'b0, acc_r[k]}
                     + {1'b0, to_offset_bin(active_r[k*WIDTH +: WIDTH])}
                     + {{WIDTH{1'b0}}, cin_s};
        end
    end

    // Accumulators and output bits; mute overrides every edge.
    always_ff @(posedge clk48m or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < CHANNELS; k++) begin
                acc_r[k] <= ACC_ZERO;
            end
            pdm_r <= {CHANNELS{1'b0}};
        end else if (mute) begin
            for (int k = 0; k < CHANNELS; k++) begin
                acc_r[k] <= ACC_ZERO;
            end
            pdm_r <= {CHANNELS{1'b0}};
        end else if (tick_s) begin
            for (int k = 0; k < CHANNELS; k++) begin
                acc_r[k] <= sum_s[k][WIDTH-1:0];
                pdm_r[k] <= sum_s[k][WIDTH];
            end
        end
    end

    assign s_ready  = !staging_full_r;
    assign pdm      = pdm_r;
    assign underrun = underrun_r;

    pdm_out_checker #(.CHANNELS(CHANNELS)) u_checker (
        .clk48m   (clk48m),
        .rst_n    (rst_n),
        .mute     (mute),
        .pdm      (pdm_r),
        .underrun (underrun_r)
    );
endmodule

// File: tb/tb_pdm_out.sv
// Scoreboard bench for pdm_out (2 channels, 8 bits, DIV=2, OSR=4): a transaction-level
// model pushes the expected post-edge outputs, which are popped and compared each cycle.
module tb_pdm_out;
    localparam int CH = 2;
    localparam int W  = 8;
    localparam int DV = 2;
    localparam int OS = 4;

    logic            clk48m = 1'b0;
    logic            rst_n  = 1'b0;
    logic [CH*W-1:0] s_data = '0;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic            mute = 1'b0;
    logic [CH-1:0]   pdm;
    logic            underrun;

    always #5 clk48m = ~clk48m;

    pdm_out #(.CHANNELS(CH), .WIDTH(W), .DIV(DV), .OSR(OS)) dut (
        .clk48m   (clk48m),
        .rst_n    (rst_n),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .mute     (mute),
        .pdm      (pdm),
        .underrun (underrun)
    );

    typedef struct packed {
        logic [CH-1:0] pdm;
        logic          und;
        logic          rdy;
        logic          tick;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    // model state
    int            m_cyc;
    bit            m_full;
    logic [CH*W-1:0] m_stage;
    logic [CH*W-1:0] m_active;
    int            m_acc[CH];
    logic [CH-1:0] m_pdm;
`ifdef PDM_DITHER_EN
    logic [15:0]   m_lfsr;
`endif

    // statistics gathered on tick cycles
    int       und_cnt;
    int       ticks;
    int       ones0;
    int       ones1;
    logic [3:0] hist;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cyc = 0;
        m_full = 1'b0;
        m_stage = '0;
        m_active = '0;
        for (int k = 0; k < CH; k++) m_acc[k] = 0;
        m_pdm = '0;
`ifdef PDM_DITHER_EN
        m_lfsr = 16'hACE1;
`endif
        exp_q.delete();
    endtask

    task automatic clear_stats();
        und_cnt = 0;
        ticks = 0;
        ones0 = 0;
        ones1 = 0;
        hist = 4'b0000;
    endtask

    // Predict the outputs after the coming edge from the inputs currently driven.
    task automatic model_step();
        bit   tick;
        bit   bnd;
        bit   acc_in;
        bit   und;
        int   u;
        int   s;
        int   cin;
        exp_t e;
        tick   = (m_cyc % DV) == DV - 1;
        bnd    = tick && (((m_cyc / DV) % OS) == OS - 1);
        acc_in = s_valid && !m_full;
        cin    = 0;
`ifdef PDM_DITHER_EN
        cin = int'(m_lfsr[0]);
`endif
        for (int k = 0; k < CH; k++) begin
            if (mute) begin
                m_acc[k] = 0;
                m_pdm[k] = 1'b0;
            end else if (tick) begin
                u = int'(m_active[k*W +: W]) ^ (1 << (W - 1));
                s = m_acc[k] + u + cin;
                m_pdm[k] = (s >= (1 << W));
                m_acc[k] = s % (1 << W);
            end
        end
        und = bnd && !m_full;
        if (bnd) begin
            if (m_full) begin
                m_active = m_stage;
                m_full = 1'b0;
            end else begin
                m_active = '0;
            end
        end
        if (acc_in) begin
            m_stage = s_data;
            m_full = 1'b1;
        end
`ifdef PDM_DITHER_EN
        if (tick) m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`endif
        m_cyc++;
        e.pdm  = m_pdm;
        e.und  = und;
        e.rdy  = !m_full;
        e.tick = tick;
        exp_q.push_back(e);
    endtask

    task automatic cycle();
        exp_t e;
        model_step();
        @(posedge clk48m);
        #1;
        check_val("sb_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val("pdm", pdm, e.pdm);
            check_val("underrun", underrun, e.und);
            check_val("s_ready", s_ready, e.rdy);
            if (underrun === 1'b1) und_cnt++;
            if (e.tick) begin
                ticks++;
                if (pdm[0] === 1'b1) ones0++;
                if (pdm[1] === 1'b1) ones1++;
                hist = {hist[2:0], pdm[0]};
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic send_frame(input logic [CH*W-1:0] d, output int waits);
        bit took;
        bit done;
        waits = 0;
        done = 1'b0;
        s_data = d;
        s_valid = 1'b1;
        while (!done) begin
            took = (s_ready === 1'b1);
            cycle();
            if (took) begin
                done = 1'b1;
            end else begin
                waits++;
                if (waits > 64) begin
                    check_val("accept_timeout", waits, 0);
                    done = 1'b1;
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        clear_stats();
        model_reset();
        #12;
        check_val("rst_s_ready", s_ready, 1);
        check_val("rst_pdm", pdm, 0);
        check_val("rst_underrun", underrun, 0);
        rst_n = 1'b1;

        // ch0=0x00, ch1=0x80: after load ch0 toggles 0,1,0,1 and ch1 stays low
        send_frame({8'h80, 8'h00}, w);
        check_val("first_accept_wait", w, 0);
        s_valid = 1'b0;
        run(7);
        clear_stats();
        run(8);
        check_val("mid_pattern_ch0", hist, 4'b0101);
        check_val("neg_full_ch1_ones", ones1, 0);
        check_val("underrun_after_frame", und_cnt, 1);

        // idle: underrun every 8 cycles, midscale 50% density
        clear_stats();
        run(16);
        check_val("idle_underruns", und_cnt, 2);
        check_val("idle_ones_ch0", ones0, 4);

        // back-to-back frames, ch0=0x40 (3/4), ch1=0xC0 (1/4)
        send_frame({8'hC0, 8'h40}, w);
        check_val("b2b_first_wait", w, 0);
        send_frame({8'hC0, 8'h40}, w);
        check_val("b2b_second_wait", w, 7);
        clear_stats();
        send_frame({8'hC0, 8'h40}, w);
        send_frame({8'hC0, 8'h40}, w);
        check_val("q40_ticks", ticks, 8);
        check_val("q40_ones_ch0", ones0, 6);
        check_val("q40_ones_ch1", ones1, 2);
        check_val("q40_no_underrun", und_cnt, 0);

        // ch0=0x7F: 255 highs in 256 ticks
        send_frame({8'h80, 8'h7F}, w);
        send_frame({8'h80, 8'h7F}, w);
        clear_stats();
        for (int i = 0; i < 64; i++) send_frame({8'h80, 8'h7F}, w);
        s_valid = 1'b0;
        check_val("max_ticks", ticks, 256);
        check_val("max_ones_ch0", ones0, 255);
        check_val("max_ones_ch1", ones1, 0);

        // mute mid-frame, then release
        send_frame({8'h80, 8'h00}, w);
        s_valid = 1'b0;
        run(3);
        mute = 1'b1;
        run(6);
        check_val("mute_pdm", pdm, 0);
        mute = 1'b0;
        run(12);

        // async reset mid-frame with staging full
        send_frame({8'h12, 8'h34}, w);
        s_valid = 1'b0;
        send_frame({8'h56, 8'h78}, w);
        s_valid = 1'b0;
        run(2);
        check_val("pre_reset_s_ready", s_ready, 0);
        rst_n = 1'b0;
        #1;
        check_val("async_rst_s_ready", s_ready, 1);
        check_val("async_rst_pdm", pdm, 0);
        check_val("async_rst_underrun", underrun, 0);
        model_reset();
        #1;
        rst_n = 1'b1;
        clear_stats();
        run(8);
        check_val("post_rst_underrun", und_cnt, 1);
        check_val("post_rst_pattern", hist, 4'b0101);
        run(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pdm_out.md
PDM_OUT -- requirements
Module: pdm_out

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent PDM output channels (1..16).
REQ-002 Parameter WIDTH, default 16: sample width per channel, two's complement (4..24).
REQ-003 Parameter DIV, default 24: clk48m cycles per PDM bit (tick); minimum 2.
REQ-004 Parameter OSR, default 64: ticks per sample frame; minimum 2.
REQ-005 Port clk48m, input, 1: sole clock; all state on rising edge.
REQ-006 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 Port s_data, input, CHANNELS*WIDTH: one frame; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 Port s_valid, input, 1: s_data valid.
REQ-009 Port s_ready, output, 1: staging buffer empty; transfer when s_valid && s_ready.
REQ-010 Port mute, input, 1: carrier-sense style mute, forces outputs low.
REQ-011 Port pdm, output, CHANNELS: registered 1-bit PDM streams.
REQ-012 Port underrun, output, 1: one-cycle pulse, frame boundary with staging empty.

Function
REQ-013 Prescaler pcnt counts 0..DIV-1 and wraps; tick is asserted in the cycle where pcnt==DIV-1.
REQ-014 Frame counter scnt advances on tick, 0..OSR-1, wraps; frame boundary = tick && scnt==OSR-1.
REQ-015 Two-stage buffer: staging (one frame plus full flag) and active (one frame).
REQ-016 s_ready = !staging_full; accepted frame is written to staging and full is set on the same edge.
REQ-017 At frame boundary with staging full: active <= staging, full cleared; s_ready rises next cycle.
REQ-018 At frame boundary with staging empty: active <= all zero (signed midscale), underrun pulses high for exactly that one cycle.
REQ-019 Accept and frame boundary in the same cycle with staging empty: the accepted frame goes to staging; underrun still fires; no bypass into active.
REQ-020 Per channel, u = active sample with MSB inverted (offset binary); accumulator acc is WIDTH bits.
REQ-021 On tick: {carry, acc} <= acc + u + cin (WIDTH+1-bit sum); pdm[k] <= carry; cin per REQ-029/030.
REQ-022 The accumulator update on a frame-boundary tick uses the active value held before that edge; the new frame takes effect on the following tick.
REQ-023 Long-run density of pdm[k] = u/2^WIDTH; sample -2^(WIDTH-1) gives constant 0.
REQ-024 mute high: on every clk48m edge pdm <= 0 and all acc <= 0; counters, buffers and handshake continue unaffected.
REQ-025 Mute release: modulation resumes at the next tick from acc=0.

Reset
REQ-026 rst_n low asynchronously sets pdm=0, underrun=0, pcnt=0, scnt=0, all acc=0, active=0, staging_full=0 (s_ready=1).
REQ-027 Reset mid-frame discards both staged and active data; the first boundary after release occurs OSR*DIV cycles after the first clock edge.
REQ-028 Deassertion is used as-is; synchronising rst_n is the integrator's responsibility.

Configuration
REQ-029 Macro PDM_DITHER_EN defined: 16-bit Fibonacci LFSR (taps 16,14,13,11), reset seed 16'hACE1, advances on each tick; cin = lfsr[0], shared by all channels; mute does not stop the LFSR.
REQ-030 PDM_DITHER_EN undefined: no LFSR logic; cin = 0; output bit-exact per REQ-021.

Verification (CHANNELS=2, WIDTH=8, DIV=2, OSR=4, dither off unless stated)
REQ-031 Frame ch0=0x00, ch1=0x80 loaded -> from the tick after load, pdm[0] = 0,1,0,1... (acc starts 0) and pdm[1] constant 0.
REQ-032 ch0=0x7F -> pdm[0] high on 255 of every 256 ticks; ch0=0x40 -> exactly 3 highs per 4 ticks.
REQ-033 s_valid held low -> underrun pulses once per 8 cycles, active=0, pdm = 50% density; s_ready stays 1.
REQ-034 Two frames offered back-to-back -> first accepted immediately, s_ready low until the next boundary, second accepted the cycle after; no frame lost or duplicated.
REQ-035 mute raised mid-frame -> pdm=0 from the next edge and acc=0; on release, pattern restarts as from reset for the current sample; underrun and s_ready timing unchanged.
REQ-036 rst_n pulsed low mid-frame with staging full -> all outputs 0, s_ready=1 immediately (asynchronously); with PDM_DITHER_EN, the LFSR returns to 16'hACE1.
